// File: rtl/dna_pkg.sv
// -----------------------------------------------------------------------------
// dna_pkg
// Shared types and constants for the DNA alignment datapath loaders.
//   base_t          2-bit nucleotide code
//   BASE_A..BASE_T  code points: A=00, C=01, G=10, T=11
//   BASES_PER_WORD  bases packed into one 32-bit memory word
//   loader_state_t  sequence loader FSM states
// -----------------------------------------------------------------------------
package dna_pkg;

  typedef logic [1:0] base_t;

  localparam base_t BASE_A = 2'b00;
  localparam base_t BASE_C = 2'b01;
  localparam base_t BASE_G = 2'b10;
  localparam base_t BASE_T = 2'b11;

  localparam int BASES_PER_WORD = 16;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    FLUSH,
    DONE
  } loader_state_t;

endpackage

// File: rtl/base_encoder.sv
// -----------------------------------------------------------------------------
// base_encoder
// Combinational ASCII nucleotide to 2-bit code converter. Case-insensitive.
// Any character other than A/C/G/T (either case) encodes as BASE_A with
// legal=0, so the caller decides whether to drop or keep it.
//   ch     in   8  ASCII character
//   base   out  2  encoded base
//   legal  out  1  character is one of ACGT/acgt
// -----------------------------------------------------------------------------
module base_encoder
  import dna_pkg::*;
(
  input  logic [7:0] ch,
  output base_t      base,
  output logic       legal
);

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    base  = BASE_A;
    legal = 1'b1;
    case (ch)
      8'h41, 8'h61: base = BASE_A;
      8'h43, 8'h63: base = BASE_C;
      8'h47, 8'h67: base = BASE_G;
      8'h54, 8'h74: base = BASE_T;
      default:      legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seq_loader.sv
// -----------------------------------------------------------------------------
// seq_loader
// Streams ASCII nucleotides into the read or reference sequence memory.
// Bases are encoded to 2 bits and packed LSB-first, DATA_WIDTH/2 per word,
// into consecutive word-aligned byte addresses. A final partial word is
// written zero-padded. Bases beyond MEM_SIZE*4 are consumed but dropped.
//
// Optional feature (macro SEQ_LOADER_CHAR_CHECK_EN):
//   defined   - illegal characters are dropped and set err_char
//   undefined - illegal characters are stored as A; err_char stays 0
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start, sel         begin a load (IDLE only); target 0=read, 1=reference
//   s_valid/s_ready    byte stream handshake
//   s_data, s_last     ASCII base, final base of the sequence
//   we/addw/din_read   read memory write port
//   we/addw/din_ref    reference memory write port
//   busy               load in progress (start acceptance through DONE)
//   done, len_out      completion pulse, stored base count
//   err_overflow       sticky: base dropped for capacity
//   err_char           sticky: illegal character seen
// -----------------------------------------------------------------------------
module seq_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sel,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [7:0]            s_data,
  input  logic                  s_last,
  output logic                  we_read,
  output logic [ADDR_WIDTH-1:0] addw_read,
  output logic [DATA_WIDTH-1:0] din_read,
  output logic                  we_ref,
  output logic [ADDR_WIDTH-1:0] addw_ref,
  output logic [DATA_WIDTH-1:0] din_ref,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           len_out,
  output logic                  err_overflow,
  output logic                  err_char
);
  import dna_pkg::*;

  localparam int BPW        = DATA_WIDTH / 2;
  localparam int FILL_W     = $clog2(BPW);
  localparam int CAPACITY   = MEM_SIZE * 4;
  localparam int CNT_W      = $clog2(CAPACITY + 1);
  localparam int WORD_BYTES = DATA_WIDTH / 8;

  loader_state_t         state;
  logic                  sel_q;
  logic [CNT_W-1:0]      count_q;   // stored bases, saturates at CAPACITY
  logic [DATA_WIDTH-1:0] word_q;    // word being assembled
  logic [ADDR_WIDTH-1:0] addw_q;
  logic [DATA_WIDTH-1:0] din_q;

  base_t                 enc_base;
  logic                  base_legal;

  logic                  beat;
  logic                  char_ok;
  logic                  cap_reached;
  logic                  store;
  logic                  do_write;
  logic [FILL_W-1:0]     fill;
  logic [DATA_WIDTH-1:0] new_word;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH-1:0] waddr;

  base_encoder u_enc (
    .ch    (s_data),
    .base  (enc_base),
    .legal (base_legal)
  );

`ifndef SEQ_LOADER_CHAR_CHECK_EN
  logic unused_legal;
  assign unused_legal = base_legal;
`endif

  // Both write ports share one address/data register; only we differs.
  assign addw_read = addw_q;
  assign addw_ref  = addw_q;
  assign din_read  = din_q;
  assign din_ref   = din_q;

  always_comb begin
    // s_ready is high exactly while in RECV, so it qualifies the beat.
    beat        = s_ready && s_valid;
`ifdef SEQ_LOADER_CHAR_CHECK_EN
    char_ok     = base_legal;
`else
    char_ok     = 1'b1;
`endif
    cap_reached = (count_q == CNT_W'(CAPACITY));
    store       = beat && char_ok && !cap_reached;
    fill        = count_q[FILL_W-1:0];
    new_word    = word_q | (DATA_WIDTH'(enc_base) << {fill, 1'b0});
    wdata       = store ? new_word : word_q;
    // Address of the word currently being filled; fill has not wrapped yet.
    waddr       = ADDR_WIDTH'(count_q >> FILL_W) * ADDR_WIDTH'(WORD_BYTES);
    // Write on a completed word, or flush a non-empty word on the last beat.
    // A dropped last beat still flushes whatever is pending.
    do_write    = (store && (fill == FILL_W'(BPW - 1))) ||
                  (beat && s_last && (store || (fill != '0)));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sel_q        <= 1'b0;
      count_q      <= '0;
      word_q       <= '0;
      addw_q       <= '0;
      din_q        <= '0;
      s_ready      <= 1'b0;
      we_read      <= 1'b0;
      we_ref       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      len_out      <= '0;
      err_overflow <= 1'b0;
      err_char     <= 1'b0;
    end else begin
      we_read <= 1'b0;
      we_ref  <= 1'b0;
      done    <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            sel_q        <= sel;
            count_q      <= '0;
            word_q       <= '0;
            len_out      <= '0;
            err_overflow <= 1'b0;
            err_char     <= 1'b0;
            busy         <= 1'b1;
            s_ready      <= 1'b1;
            state        <= RECV;
          end
        end

        RECV: begin
          if (store) count_q <= count_q + CNT_W'(1);

          if (do_write) begin
            we_read <= !sel_q;
            we_ref  <= sel_q;
            addw_q  <= waddr;
            din_q   <= wdata;
            word_q  <= '0;
          end else if (store) begin
            word_q  <= new_word;
          end

          if (beat && char_ok && cap_reached) err_overflow <= 1'b1;
`ifdef SEQ_LOADER_CHAR_CHECK_EN
          if (beat && !base_legal) err_char <= 1'b1;
`endif

          if (beat && s_last) begin
            s_ready <= 1'b0;
            state   <= FLUSH;
          end
        end

        // The flush write (if any) was registered on the way in and is
        // presented on the memory port during this cycle.
        FLUSH: begin
          done    <= 1'b1;
          len_out <= 16'(count_q);
          state   <= DONE;
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_loader.sv
// -----------------------------------------------------------------------------
// tb_seq_loader
// Self-checking bench for seq_loader. Each load is driven with random valid
// gaps and random start/sel noise, and the captured memory writes, len_out
// and error flags are compared against a reference computed from the base
// list: filter, then pack 16 per word.
// -----------------------------------------------------------------------------
module tb_seq_loader;

  localparam int CAP = 2048;

  typedef logic [7:0] bq_t[$];

  typedef struct packed {
    logic        tgt;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h00;
  logic        s_last = 1'b0;
  logic        we_read;
  logic [31:0] addw_read;
  logic [31:0] din_read;
  logic        we_ref;
  logic [31:0] addw_ref;
  logic [31:0] din_ref;
  logic        busy;
  logic        done;
  logic [15:0] len_out;
  logic        err_overflow;
  logic        err_char;

  int n_checks = 0;
  int n_errors = 0;
  wr_t wr_q[$];

  seq_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sel          (sel),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .we_read      (we_read),
    .addw_read    (addw_read),
    .din_read     (din_read),
    .we_ref       (we_ref),
    .addw_ref     (addw_ref),
    .din_ref      (din_ref),
    .busy         (busy),
    .done         (done),
    .len_out      (len_out),
    .err_overflow (err_overflow),
    .err_char     (err_char)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capture every memory write away from the rising edge.
  always @(negedge clk) begin
    if (!rst && (we_read || we_ref)) begin
      check("one_we", {62'd0, we_read, we_ref} & 64'h3, we_ref ? 64'h1 : 64'h2);
      check("bus_match", {addw_ref, din_ref}, {addw_read, din_read});
      wr_q.push_back('{tgt: we_ref, addr: addw_read, data: din_read});
    end
  end

  // Reference encoding: -1 for an illegal character.
  function automatic int enc(input logic [7:0] c);
    logic [7:0] u;
    u = c & 8'hDF;
    if (u == "A") return 0;
    if (u == "C") return 1;
    if (u == "G") return 2;
    if (u == "T") return 3;
    return -1;
  endfunction

  task automatic str_to_q(input string s, output bq_t q);
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endtask

  task automatic run_load(input string tag, input logic tgt, input bq_t chars, input int gap_pct);
    int          stored[$];
    bit          exp_ovf;
    bit          exp_chr;
    int          nw;
    int          i;
    int          guard;
    int          t;
    logic [31:0] w;

    // Reference model.
    exp_ovf = 0;
    exp_chr = 0;
    foreach (chars[k]) begin
      int code;
      code = enc(chars[k]);
      if (code < 0) begin
`ifdef SEQ_LOADER_CHAR_CHECK_EN
        exp_chr = 1;
        continue;
`else
        code = 0;
`endif
      end
      if (stored.size() == CAP) exp_ovf = 1;
      else stored.push_back(code);
    end
    nw = (stored.size() + 15) / 16;

    check({tag, ":stray_writes"}, 64'(wr_q.size()), 64'd0);
    wr_q.delete();

    // Start pulse; a valid beat in IDLE must be ignored.
    @(negedge clk);
    sel = tgt; start = 1'b1; s_valid = 1'b1; s_data = "T"; s_last = 1'b1;
    @(negedge clk);
    start = 1'b0; sel = ~tgt; s_valid = 1'b0; s_last = 1'b0;
    check({tag, ":busy_on"}, 64'(busy), 64'd1);
    check({tag, ":ready_on"}, 64'(s_ready), 64'd1);

    i = 0;
    guard = 0;
    while (i < chars.size() && guard < 20000) begin
      if ($urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
        start   = 1'($urandom);     // ignored while busy
        sel     = 1'($urandom);
      end else begin
        s_valid = 1'b1;
        s_data  = chars[i];
        s_last  = (i == chars.size() - 1);
        if (s_ready) i++;
      end
      @(negedge clk);
      guard++;
    end
    s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
    check({tag, ":all_beats_taken"}, 64'(i), 64'(chars.size()));

    t = 0;
    while (!done && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, ":done"}, 64'(done), 64'd1);
    check({tag, ":len_out"}, 64'(len_out), 64'(stored.size()));
    check({tag, ":err_overflow"}, 64'(err_overflow), 64'(exp_ovf));
    check({tag, ":err_char"}, 64'(err_char), 64'(exp_chr));
    @(negedge clk);
    check({tag, ":done_pulse"}, 64'(done), 64'd0);
    check({tag, ":busy_off"}, 64'(busy), 64'd0);

    check({tag, ":n_writes"}, 64'(wr_q.size()), 64'(nw));
    for (int wi = 0; wi < nw && wi < wr_q.size(); wi++) begin
      w = '0;
      for (int k = 0; k < 16; k++)
        if (wi * 16 + k < stored.size())
          w = w | (32'(stored[wi * 16 + k]) << (2 * k));
      check({tag, ":tgt"},  64'(wr_q[wi].tgt),  64'(tgt));
      check({tag, ":addr"}, 64'(wr_q[wi].addr), 64'(wi * 4));
      check({tag, ":data"}, 64'(wr_q[wi].data), 64'(w));
    end
    wr_q.delete();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bq_t   q;
    string pool;
    string bad;

    // Reset state.
    #12;
    check("rst_ctrl", {41'd0, s_ready, we_read, we_ref, busy, done, err_overflow, err_char, len_out}, 64'd0);
    check("rst_read_bus", {addw_read, din_read}, 64'd0);
    check("rst_ref_bus", {addw_ref, din_ref}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed loads.
    str_to_q("ACGTACGTACGTACGT", q);
    run_load("acgt16", 1'b0, q, 0);

    str_to_q("AAAAAAAAAAAAAAAAT", q);
    run_load("a16t", 1'b1, q, 20);

    str_to_q("gc", q);
    run_load("gc", 1'b0, q, 0);

    q = {};
    for (int k = 0; k < CAP + 1; k++) q.push_back("C");
    run_load("overflow", 1'b0, q, 0);

    str_to_q("ANC", q);
    run_load("anc", 1'b1, q, 0);

    // Reset in the middle of a load.
    @(negedge clk);
    sel = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1; s_data = "G"; s_last = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_ctrl", {41'd0, s_ready, we_read, we_ref, busy, done, err_overflow, err_char, len_out}, 64'd0);
    check("midrst_bus", {addw_read, din_read, addw_ref[15:0], din_ref[15:0]}, 64'd0);
    check("midrst_no_write", 64'(wr_q.size()), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    str_to_q("TTTTCCCCAAAAGGGG", q);
    run_load("after_rst", 1'b0, q, 10);

    // Random loads.
    pool = "ACGTacgt";
    bad  = "NX-n";
    for (int r = 0; r < 12; r++) begin
      int len;
      len = $urandom_range(70, 1);
      q = {};
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(14) == 0) q.push_back(bad[$urandom_range(3)]);
        else q.push_back(pool[$urandom_range(7)]);
      end
      run_load($sformatf("rand%0d", r), 1'($urandom), q, 30);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
